fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
- Sequencer and arbiter that shares one free-running fpu adder (32-bit custom format: sign[31], exp[30:25], mant[24:0]) between two requesters.
- Accepts operand pairs over valid/ready, grants round-robin, holds operands on the fpu until its result has settled, then captures data and status.
- Returns data and status with the requester id over a valid/ready response channel.
- Sits between the fpu and its client blocks. Only one operation is in flight at a time.

Parameters:
- SETTLE_CYCLES, 100: cycles operands are held before sampling. Must cover 3 worst-case fpu passes of about 33 cycles each. Legal range 8..255.
- CNT_W, 8: settle-counter width.

Ports:
- clock100KHz  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 handshake.
- req0_op_a  in  32  requester 0 operand A.
- req0_op_b  in  32  requester 0 operand B.
- req0_sub  in  1  requester 0 subtract: A-B instead of A+B.
- req1_valid, req1_ready, req1_op_a, req1_op_b, req1_sub: same as requester 0, for requester 1.
- fpu_op_a  out  32  to fpu op_A_in.
- fpu_op_b  out  32  to fpu op_B_in.
- fpu_data  in  32  from fpu data_out.
- fpu_status  in  4  from fpu status_out; one-hot EXACT=0001, INEXACT=0010, OVERFLOW=0100, UNDERFLOW=1000.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester that owns the result.
- resp_data  out  32  captured result.
- resp_status  out  4  captured status.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; last_grant=1, so req0 wins first.
  - fpu_op_a=fpu_op_b=0; counter=0.
  - resp_valid=0, resp_id=0, resp_data=0, resp_status=0; req*_ready=0.
  - A reset mid-operation abandons the operation silently.
- States: IDLE -> HOLD -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - Grant is combinational: if only one valid, grant it. If both valid, grant the requester other than last_grant.
  - reqN_ready=1 only in IDLE and only for the granted N. A transfer occurs on valid&&ready.
  - On transfer, register in the same edge:
    - fpu_op_a = op_a;
    - fpu_op_b = op_b with bit31 inverted when sub=1;
    - owner id; last_grant=N; counter=0; go to HOLD.
- HOLD:
  - fpu_op_a/b stay stable; counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - resp_data<=fpu_data, resp_status<=fpu_status, resp_id<=owner, resp_valid<=1; go to RESP.
- RESP:
  - Hold resp_* stable while resp_valid && !resp_ready.
  - On resp_ready: resp_valid<=0, go to IDLE. No new grant in that same cycle.
- Latency from request acceptance to resp_valid: SETTLE_CYCLES+1 cycles.
- Minimum issue interval: SETTLE_CYCLES+3 cycles.
- Requester rules:
  - A requester must not drop valid or change operands before ready.
  - Ready never depends on resp_ready.
- Status is forwarded unmodified. Overflow/underflow data is whatever the fpu presents (0 by fpu rule).
- After reset, fpu_op_a/b stay at 0 until the first grant.

Optional Feature:
- Macro FPU_ARB_STATS_EN.
- When defined, adds outputs stat_ops (16), stat_inexact (16), stat_ovf (16), stat_unf (16), all saturating at 16'hFFFF:
  - stat_ops increments on each CAPTURE.
  - The others increment on CAPTURE when the matching fpu_status bit is set.
  - All reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fpu_pkg: status one-hot enum (EXACT/INEXACT/OVERFLOW/UNDERFLOW), field-position constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=25, MANT_W=25), arbiter state enum.
- One sub-module, rr_arb2: 2-way round-robin grant from valid bits and last_grant. The FSM stays in fpu_arbiter.

Test Plan:
- Single add: req0 A=B=0x40000000, sub=0 -> after SETTLE_CYCLES+1 cycles, resp_valid=1, resp_id=0, resp_data=0x42000000, resp_status=0001.
- Subtract path: req1 A=0x42000000, B=0x40000000, sub=1 -> fpu_op_b observed as 0xC0000000 during HOLD; resp_id=1, resp_data=0x40000000, resp_status=0001.
- Overflow: req0 A=B=0x7E000000 -> resp_data=0x00000000, resp_status=0100.
- Contention and backpressure:
  - both valid from reset -> grants in order req0, req1, req0.
  - Hold resp_ready=0 for 20 cycles -> resp_* stable, and no ready asserted until one cycle after the resp handshake.
- Reset mid-HOLD: assert reset at counter=50 -> resp_valid=0, fpu_op_a=fpu_op_b=0, IDLE. The next request completes normally with full latency.
- FPU_ARB_STATS_EN defined: run the three operations above -> stat_ops=3, stat_ovf=1, stat_inexact=0, stat_unf=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and field positions for the fpu arbiter slice.
// Custom float format: sign[31], exp[30:25], mant[24:0].
package fpu_pkg;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 25;
    localparam int MANT_W   = 25;

    typedef enum logic [3:0] {
        ST_EXACT     = 4'b0001,
        ST_INEXACT   = 4'b0010,
        ST_OVERFLOW  = 4'b0100,
        ST_UNDERFLOW = 4'b1000
    } fpu_status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_CAPTURE,
        S_RESP
    } arb_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on contention the requester that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);
    always_comb begin
        grant_id = (valid == 2'b11) ? ~last_grant : valid[1];
        grant    = (valid == 2'b00) ? 2'b00 : (grant_id ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one free-running fpu adder between two requesters, holding operands until settled.
// Define FPU_ARB_STATS_EN to add saturating operation/status counters.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 100,
    parameter int CNT_W         = 8
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op_a,
    input  logic [31:0] req0_op_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op_a,
    input  logic [31:0] req1_op_b,
    input  logic        req1_sub,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic [3:0]  resp_status
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_inexact,
    output logic [15:0] stat_ovf,
    output logic [15:0] stat_unf
`endif
);
    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fpu_op_a_q, fpu_op_a_d, fpu_op_b_q, fpu_op_b_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [3:0]       resp_status_q, resp_status_d;
    logic             resp_valid_q, resp_valid_d, resp_id_q, resp_id_d;
    logic [1:0]       grant;
    logic             grant_id, idle, sel_sub;

    rr_arb2 u_arb (
        .valid     ({req1_valid, req0_valid}),
        .last_grant(last_grant_q),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign idle        = state_q == S_IDLE;
    assign req0_ready  = idle && grant[0] && !reset;
    assign req1_ready  = idle && grant[1] && !reset;
    assign sel_sub     = grant_id ? req1_sub : req0_sub;
    assign fpu_op_a    = fpu_op_a_q;
    assign fpu_op_b    = fpu_op_b_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        fpu_op_a_d    = fpu_op_a_q;
        fpu_op_b_d    = fpu_op_b_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        case (state_q)
            S_IDLE: if (req0_ready || req1_ready) begin
                fpu_op_a_d   = grant_id ? req1_op_a : req0_op_a;
                // Subtraction is an add with B's sign flipped.
                fpu_op_b_d   = (grant_id ? req1_op_b : req0_op_b) ^ (32'(sel_sub) << SIGN_BIT);
                owner_d      = grant_id;
                last_grant_d = grant_id;
                cnt_d        = '0;
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? S_CAPTURE : S_HOLD;
            end
            S_CAPTURE: begin
                resp_data_d   = fpu_data;
                resp_status_d = fpu_status;
                resp_id_d     = owner_q;
                resp_valid_d  = 1'b1;
                state_d       = S_RESP;
            end
            S_RESP: if (resp_ready) begin
                resp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            fpu_op_a_q    <= '0;
            fpu_op_b_q    <= '0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            fpu_op_a_q    <= fpu_op_a_d;
            fpu_op_b_q    <= fpu_op_b_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
        end
    end

`ifdef FPU_ARB_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d, stat_inexact_q, stat_inexact_d;
    logic [15:0] stat_ovf_q, stat_ovf_d, stat_unf_q, stat_unf_d;
    logic        cap;

    assign cap          = state_q == S_CAPTURE;
    assign stat_ops     = stat_ops_q;
    assign stat_inexact = stat_inexact_q;
    assign stat_ovf     = stat_ovf_q;
    assign stat_unf     = stat_unf_q;

    always_comb begin
        stat_ops_d     = sat_inc(stat_ops_q, cap);
        stat_inexact_d = sat_inc(stat_inexact_q, cap && |(fpu_status & ST_INEXACT));
        stat_ovf_d     = sat_inc(stat_ovf_q, cap && |(fpu_status & ST_OVERFLOW));
        stat_unf_d     = sat_inc(stat_unf_q, cap && |(fpu_status & ST_UNDERFLOW));
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            stat_ops_q     <= '0;
            stat_inexact_q <= '0;
            stat_ovf_q     <= '0;
            stat_unf_q     <= '0;
        end else begin
            stat_ops_q     <= stat_ops_d;
            stat_inexact_q <= stat_inexact_d;
            stat_ovf_q     <= stat_ovf_d;
            stat_unf_q     <= stat_unf_d;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: scoreboard bench with a slow behavioural fpu that only presents a valid result once its operands are stable.
module tb_fpu_arbiter;
    localparam int SETTLE = 100;

    logic        clk = 0, rst = 1;
    logic        v0 = 0, v1 = 0, s0 = 0, s1 = 0;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic        rdy0, rdy1;
    logic [31:0] fpu_op_a, fpu_op_b, fpu_data;
    logic [3:0]  fpu_status;
    logic        resp_valid, resp_ready = 0, resp_id;
    logic [31:0] resp_data;
    logic [3:0]  resp_status;
`ifdef FPU_ARB_STATS_EN
    logic [15:0] stat_ops, stat_inexact, stat_ovf, stat_unf;
    int n_ops = 0, n_inx = 0, n_ovf = 0, n_unf = 0;
`endif
    int checks = 0, failures = 0;
    int rr_mode = 2;
    int cyc = 0, acc_cyc = 0;
    bit busy = 0, last_m = 1, have_cur = 0;
    int ord[$];
    int resp_log[$];
    logic [35:0] q0[$], q1[$];
    logic [36:0] cur;
    logic [31:0] exp_fa = 0, exp_fb = 0;
    logic [31:0] prev_a = 0, prev_b = 0;
    int stab = 0;
    logic [35:0] fpu_r;

    fpu_arbiter dut (
        .clock100KHz(clk), .reset(rst),
        .req0_valid(v0), .req0_ready(rdy0), .req0_op_a(a0), .req0_op_b(b0), .req0_sub(s0),
        .req1_valid(v1), .req1_ready(rdy1), .req1_op_a(a1), .req1_op_b(b1), .req1_sub(s1),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_data(fpu_data), .fpu_status(fpu_status),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_status(resp_status)
`ifdef FPU_ARB_STATS_EN
        , .stat_ops(stat_ops), .stat_inexact(stat_inexact), .stat_ovf(stat_ovf), .stat_unf(stat_unf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Value-level adder: align, add signed magnitudes, renormalise, truncate.
    function automatic logic [35:0] fpu_fn(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi, lo;
        longint mh, ml, s, m;
        int e, d;
        bit lost;
        if (y[30:25] > x[30:25]) begin hi = y; lo = x; end else begin hi = x; lo = y; end
        mh = (hi[30:25] == 0) ? 0 : ((longint'(1) << 25) | longint'(hi[24:0]));
        ml = (lo[30:25] == 0) ? 0 : ((longint'(1) << 25) | longint'(lo[24:0]));
        e = int'(hi[30:25]);
        d = e - int'(lo[30:25]);
        if (d > 40) begin
            lost = ml != 0;
            ml = 0;
        end else begin
            lost = (ml & ((longint'(1) << d) - 1)) != 0;
            ml = ml >>> d;
        end
        s = (hi[31] ? -mh : mh) + (lo[31] ? -ml : ml);
        m = (s < 0) ? -s : s;
        if (m == 0) return {4'b0001, 32'h0};
        while (m >= (longint'(1) << 26)) begin lost |= m[0]; m = m >>> 1; e++; end
        while (m < (longint'(1) << 25)) begin m = m <<< 1; e--; end
        if (e > 63) return {4'b0100, 32'h0};
        if (e < 1) return {4'b1000, 32'h0};
        return {lost ? 4'b0010 : 4'b0001, s < 0, 6'(e), m[24:0]};
    endfunction

    // The fpu output is garbage until its inputs have been stable ~90 cycles.
    always @(posedge clk) begin
        if (fpu_op_a != prev_a || fpu_op_b != prev_b) begin
            prev_a <= fpu_op_a;
            prev_b <= fpu_op_b;
            stab <= 0;
        end else if (stab < 1000) stab <= stab + 1;
    end
    always_comb begin
        fpu_r = fpu_fn(fpu_op_a, fpu_op_b);
        fpu_data = (stab >= 90) ? fpu_r[31:0] : 32'hBAD0BAD0;
        fpu_status = (stab >= 90) ? fpu_r[35:32] : 4'b0000;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_grant(input logic va, input logic vb, input bit last);
        if (va && vb) return last ? 2'b01 : 2'b10;
        return {vb, va};
    endfunction

    always @(negedge clk) begin
        logic [1:0] er;
        logic [35:0] e;
        int id;
        if (rst) begin
            ord.delete(); q0.delete(); q1.delete();
            busy = 0; last_m = 1; have_cur = 0; exp_fa = 0; exp_fb = 0;
`ifdef FPU_ARB_STATS_EN
            n_ops = 0; n_inx = 0; n_ovf = 0; n_unf = 0;
`endif
        end else begin
            chk("fpu_op_a", 64'(fpu_op_a), 64'(exp_fa));
            chk("fpu_op_b", 64'(fpu_op_b), 64'(exp_fb));
            er = busy ? 2'b00 : model_grant(v0, v1, last_m);
            chk("req_ready", 64'({rdy1, rdy0}), 64'(er));
            if (er != 2'b00) begin
                id = int'(er[1]);
                ord.push_back(id);
                busy = 1;
                last_m = er[1];
                acc_cyc = cyc + 1;
                exp_fa = er[1] ? a1 : a0;
                exp_fb = (er[1] ? b1 : b0) ^ {(er[1] ? s1 : s0), 31'b0};
            end
            if (resp_valid) begin
                if (!have_cur) begin
                    if (ord.size() == 0) chk("resp_valid_unexpected", 64'(resp_valid), 0);
                    else begin
                        id = ord.pop_front();
                        if (id == 1 && q1.size() > 0) e = q1.pop_front();
                        else if (id == 0 && q0.size() > 0) e = q0.pop_front();
                        else e = '1;
                        cur = {id[0], e};
                        have_cur = 1;
                        chk("resp_id", 64'(resp_id), 64'(id));
                        chk("resp_data", 64'(resp_data), 64'(e[31:0]));
                        chk("resp_status", 64'(resp_status), 64'(e[35:32]));
                        chk("latency", 64'(cyc - acc_cyc), 64'(SETTLE + 1));
                        resp_log.push_back(int'(resp_id));
`ifdef FPU_ARB_STATS_EN
                        n_ops++;
                        if (e[33]) n_inx++;
                        if (e[34]) n_ovf++;
                        if (e[35]) n_unf++;
`endif
                    end
                end else chk("resp_stable", 64'({resp_id, resp_status, resp_data}), 64'(cur));
                if (resp_ready) begin have_cur = 0; busy = 0; end
            end else if (have_cur) chk("resp_valid_held", 64'(resp_valid), 1);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        resp_ready = (rr_mode == 2) || (rr_mode == 0 && $urandom_range(0, 1) == 1);
    end

    task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [35:0] e);
        bit ok = 0;
        @(posedge clk); #1;
        if (id) begin q1.push_back(e); a1 = a; b1 = b; s1 = sub; v1 = 1; end
        else begin q0.push_back(e); a0 = a; b0 = b; s0 = sub; v0 = 1; end
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = id ? rdy1 : rdy0;
        end
        if (!ok) chk(id ? "req1_timeout" : "req0_timeout", 64'(id ? rdy1 : rdy0), 1);
        @(posedge clk); #1;
        if (id) begin v1 = 0; a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1)); end
        else begin v0 = 0; a0 = $urandom; b0 = $urandom; s0 = 1'($urandom_range(0, 1)); end
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((busy || ord.size() != 0 || resp_valid) && i < 5000) begin @(negedge clk); i++; end
        if (i >= 5000) chk("idle_timeout", 64'(int'(busy) + ord.size()), 0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_fp();
        int r = $urandom_range(0, 9);
        logic [5:0] e;
        e = (r == 0) ? 6'($urandom_range(60, 63)) : (r == 1) ? 6'($urandom_range(1, 3)) : 6'($urandom_range(20, 44));
        return {1'($urandom_range(0, 1)), e, 25'($urandom)};
    endfunction

    task automatic rand_req(input bit id, input int n);
        logic [31:0] a, b;
        logic sub;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 8)) @(posedge clk);
            a = rand_fp();
            b = rand_fp();
            sub = 1'($urandom_range(0, 1));
            drive(id, a, b, sub, fpu_fn(a, b ^ {sub, 31'b0}));
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ordv, i;
        v0 = 1; v1 = 1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'({rdy1, rdy0}), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_fields", 64'({resp_id, resp_status, resp_data}), 0);
        chk("rst_fpu_ops", {fpu_op_a, fpu_op_b}, 0);
        v0 = 0; v1 = 0;
        @(posedge clk); #1 rst = 0;

        drive(0, 32'h40000000, 32'h40000000, 0, {4'b0001, 32'h42000000});
        wait_idle();
        drive(1, 32'h42000000, 32'h40000000, 1, {4'b0001, 32'h40000000});
        repeat (10) @(negedge clk);
        chk("sub_fpu_op_b", 64'(fpu_op_b), 64'h C0000000);
        wait_idle();
        drive(0, 32'h7E000000, 32'h7E000000, 0, {4'b0100, 32'h00000000});
        wait_idle();
`ifdef FPU_ARB_STATS_EN
        chk("stat_ops", 64'(stat_ops), 3);
        chk("stat_ovf", 64'(stat_ovf), 1);
        chk("stat_inexact", 64'(stat_inexact), 0);
        chk("stat_unf", 64'(stat_unf), 0);
`endif

        rr_mode = 1;
        fork
            drive(0, 32'h40000000, 32'h3E800000, 0, fpu_fn(32'h40000000, 32'h3E800000));
            drive(1, 32'h41000000, 32'h40400000, 1, fpu_fn(32'h41000000, 32'hC0400000));
            begin
                i = 0;
                while (!resp_valid && i < 500) begin @(negedge clk); i++; end
                chk("bp_resp_seen", 64'(resp_valid), 1);
                repeat (20) @(negedge clk);
                chk("bp_still_valid", 64'(resp_valid), 1);
                rr_mode = 2;
            end
        join
        wait_idle();

        drive(0, 32'h40000000, 32'h40000000, 0, {4'b0001, 32'h42000000});
        repeat (50) @(posedge clk);
        #1 rst = 1;
        v0 = 1; a0 = 32'h40000000; b0 = 32'h40000000;
        @(negedge clk);
        chk("midrst_resp_valid", 64'(resp_valid), 0);
        chk("midrst_fpu_ops", {fpu_op_a, fpu_op_b}, 0);
        chk("midrst_ready", 64'({rdy1, rdy0}), 0);
        v0 = 0;
        @(posedge clk); #1 rst = 0;

        resp_log.delete();
        fork
            begin
                drive(0, 32'h40000000, 32'h40000000, 0, {4'b0001, 32'h42000000});
                drive(0, 32'h44000000, 32'h40000000, 0, fpu_fn(32'h44000000, 32'h40000000));
            end
            drive(1, 32'h42000000, 32'h40000000, 1, {4'b0001, 32'h40000000});
        join
        wait_idle();
        ordv = (resp_log.size() == 3) ? resp_log[0] * 100 + resp_log[1] * 10 + resp_log[2] : -1;
        chk("grant_order", 64'(ordv), 10);

        rr_mode = 0;
        fork
            rand_req(0, 12);
            rand_req(1, 12);
        join
        rr_mode = 2;
        wait_idle();
`ifdef FPU_ARB_STATS_EN
        chk("stat_ops_end", 64'(stat_ops), 64'(n_ops));
        chk("stat_inexact_end", 64'(stat_inexact), 64'(n_inx));
        chk("stat_ovf_end", 64'(stat_ovf), 64'(n_ovf));
        chk("stat_unf_end", 64'(stat_unf), 64'(n_unf));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
